// File: rtl/axi_slave_ram_if.sv
// AXI4 slave-side bundle for axi_slave_ram: AW/W/B/AR/R channels, 1-bit IDs.
// Sideband fields the RAM ignores (size, lock, cache, prot, qos, user) are not carried.
interface axi_slave_ram_if #(
    parameter int DW = 32
);
    logic              S_AXI_AWID;
    logic [31:0]       S_AXI_AWADDR;
    logic [7:0]        S_AXI_AWLEN;
    logic [1:0]        S_AXI_AWBURST;
    logic              S_AXI_AWVALID;
    logic              S_AXI_AWREADY;
    logic [DW-1:0]     S_AXI_WDATA;
    logic [DW/8-1:0]   S_AXI_WSTRB;
    logic              S_AXI_WLAST;
    logic              S_AXI_WVALID;
    logic              S_AXI_WREADY;
    logic              S_AXI_BID;
    logic [1:0]        S_AXI_BRESP;
    logic              S_AXI_BVALID;
    logic              S_AXI_BREADY;
    logic              S_AXI_ARID;
    logic [31:0]       S_AXI_ARADDR;
    logic [7:0]        S_AXI_ARLEN;
    logic [1:0]        S_AXI_ARBURST;
    logic              S_AXI_ARVALID;
    logic              S_AXI_ARREADY;
    logic              S_AXI_RID;
    logic [DW-1:0]     S_AXI_RDATA;
    logic [1:0]        S_AXI_RRESP;
    logic              S_AXI_RLAST;
    logic              S_AXI_RVALID;
    logic              S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWBURST, S_AXI_AWVALID,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID, S_AXI_BREADY,
        input  S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARBURST, S_AXI_ARVALID,
        input  S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_ARREADY, S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID
    );

    modport master (
        output S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWBURST, S_AXI_AWVALID,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID, S_AXI_BREADY,
        output S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARBURST, S_AXI_ARVALID,
        output S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_ARREADY, S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID
    );
endinterface

// File: rtl/axi_slave_ram.sv
// AXI4 slave on a read-first dual-port RAM; first RVALID two edges after AR, then 1 beat/cycle.
// Backpressure: W accepted every WVALID cycle; R/B hold stable until RREADY/BREADY.
module axi_slave_ram #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_MEM_ADDR_WIDTH   = 10
) (
    input  logic           ACLK,
    input  logic           ARESETN,
    axi_slave_ram_if.slave s_axi
);
    localparam int NB    = C_S_AXI_DATA_WIDTH / 8;
    localparam int BW    = $clog2(NB);
    localparam int AW    = C_MEM_ADDR_WIDTH;
    localparam int DEPTH = 1 << AW;

    localparam logic [1:0] W_IDLE  = 2'd0;
    localparam logic [1:0] W_DATA  = 2'd1;
    localparam logic [1:0] W_RESP  = 2'd2;
    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_FETCH = 2'd1;
    localparam logic [1:0] R_DATA  = 2'd2;

    // Holds the address READYs low until the first edge after reset release.
    logic live;

    logic [1:0]    w_state;
    logic          w_id;
    logic [AW-1:0] w_idx;
    logic [7:0]    w_len;
    logic [7:0]    w_beat;
    logic          w_fixed;
    logic          w_err;
    logic          aw_hs, w_hs, b_hs, w_last_beat;

    logic [1:0]    r_state;
    logic          r_id;
    logic [AW-1:0] r_idx;
    logic [AW-1:0] r_next_idx;
    logic [7:0]    r_len;
    logic [7:0]    r_beat;
    logic          r_fixed;
    logic          r_prime;
    logic          ar_hs, r_hs, r_last;

    logic [C_S_AXI_DATA_WIDTH-1:0] mem [0:DEPTH-1];
    logic [C_S_AXI_DATA_WIDTH-1:0] rd_q;
    logic                          rd_en;
    logic [AW-1:0]                 rd_idx;
    logic                          unused_addr_bits;

    assign unused_addr_bits = ^{s_axi.S_AXI_AWADDR, s_axi.S_AXI_ARADDR};

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) live <= 1'b0;
        else          live <= 1'b1;
    end

    assign aw_hs       = s_axi.S_AXI_AWVALID && s_axi.S_AXI_AWREADY;
    assign w_hs        = s_axi.S_AXI_WVALID && s_axi.S_AXI_WREADY;
    assign b_hs        = s_axi.S_AXI_BVALID && s_axi.S_AXI_BREADY;
    assign w_last_beat = (w_beat == w_len);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state <= W_IDLE;
            w_id    <= 1'b0;
            w_idx   <= '0;
            w_len   <= 8'd0;
            w_beat  <= 8'd0;
            w_fixed <= 1'b0;
            w_err   <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: if (aw_hs) begin
                    w_id    <= s_axi.S_AXI_AWID;
                    w_idx   <= s_axi.S_AXI_AWADDR[AW+BW-1:BW];
                    w_len   <= s_axi.S_AXI_AWLEN;
                    w_fixed <= (s_axi.S_AXI_AWBURST == 2'b00);
                    w_beat  <= 8'd0;
                    w_err   <= 1'b0;
                    w_state <= W_DATA;
                end
                W_DATA: if (w_hs) begin
                    // LEN alone ends the burst; a misplaced WLAST only flags SLVERR.
                    if (s_axi.S_AXI_WLAST != w_last_beat) w_err <= 1'b1;
                    if (!w_fixed) w_idx <= w_idx + AW'(1);
                    w_beat <= w_beat + 8'd1;
                    if (w_last_beat) w_state <= W_RESP;
                end
                W_RESP: if (b_hs) w_state <= W_IDLE;
                default: w_state <= W_IDLE;
            endcase
        end
    end

    assign s_axi.S_AXI_AWREADY = live && (w_state == W_IDLE);
    assign s_axi.S_AXI_WREADY  = (w_state == W_DATA);
    assign s_axi.S_AXI_BVALID  = (w_state == W_RESP);
    assign s_axi.S_AXI_BRESP   = (w_state == W_RESP) ? {w_err, 1'b0} : 2'b00;
    assign s_axi.S_AXI_BID     = w_id;

    assign ar_hs      = s_axi.S_AXI_ARVALID && s_axi.S_AXI_ARREADY;
    assign r_hs       = s_axi.S_AXI_RVALID && s_axi.S_AXI_RREADY;
    assign r_last     = (r_beat == r_len);
    assign r_next_idx = r_fixed ? r_idx : r_idx + AW'(1);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state <= R_IDLE;
            r_id    <= 1'b0;
            r_idx   <= '0;
            r_len   <= 8'd0;
            r_beat  <= 8'd0;
            r_fixed <= 1'b0;
            r_prime <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: if (ar_hs) begin
                    r_id    <= s_axi.S_AXI_ARID;
                    r_idx   <= s_axi.S_AXI_ARADDR[AW+BW-1:BW];
                    r_len   <= s_axi.S_AXI_ARLEN;
                    r_fixed <= (s_axi.S_AXI_ARBURST == 2'b00);
                    r_beat  <= 8'd0;
                    r_prime <= 1'b0;
                    r_state <= R_FETCH;
                end
                // Two fetch cycles: the first reads the word, the second holds it.
                R_FETCH: begin
                    if (r_prime) r_state <= R_DATA;
                    else         r_prime <= 1'b1;
                end
                R_DATA: if (r_hs) begin
                    if (r_last) begin
                        r_state <= R_IDLE;
                    end else begin
                        r_idx  <= r_next_idx;
                        r_beat <= r_beat + 8'd1;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_en  = 1'b0;
        rd_idx = r_idx;
        case (r_state)
            R_FETCH: rd_en = !r_prime;
            R_DATA: begin
                rd_en = 1'b1;
                if (r_hs && !r_last) rd_idx = r_next_idx;
            end
            default: rd_en = 1'b0;
        endcase
    end

    // Read-first: a same-word read and write on one edge returns the old word.
    always_ff @(posedge ACLK) begin
        if (w_hs) begin
            for (int b = 0; b < NB; b++) begin
                if (s_axi.S_AXI_WSTRB[b]) mem[w_idx][b*8 +: 8] <= s_axi.S_AXI_WDATA[b*8 +: 8];
            end
        end
        if (rd_en) rd_q <= mem[rd_idx];
    end

    assign s_axi.S_AXI_ARREADY = live && (r_state == R_IDLE);
    assign s_axi.S_AXI_RVALID  = (r_state == R_DATA);
    assign s_axi.S_AXI_RDATA   = (r_state == R_DATA) ? rd_q : '0;
    assign s_axi.S_AXI_RLAST   = (r_state == R_DATA) && r_last;
    assign s_axi.S_AXI_RRESP   = 2'b00;
    assign s_axi.S_AXI_RID     = r_id;
endmodule

// File: tb/tb_axi_slave_ram.sv
// Randomised AXI master against a word-array model of the RAM contents.
module tb_axi_slave_ram;
    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [1:0] WRAP  = 2'b10;

    logic aclk = 1'b0;
    logic aresetn;
    always #5 aclk = ~aclk;

    axi_slave_ram_if #(.DW(32)) bus ();
    axi_slave_ram #(.C_S_AXI_DATA_WIDTH(32), .C_MEM_ADDR_WIDTH(10)) dut (
        .ACLK(aclk), .ARESETN(aresetn), .s_axi(bus)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] ref_mem [1024];
    logic [31:0] wdat [256];
    logic [3:0]  wstb [256];
    logic [31:0] rdat [256];
    logic        rlst [256];

    logic [1:0] bresp;
    logic       bid, rid_s;
    bit         wok, rok;
    int         lat;

    function automatic int word_at(input logic [31:0] addr, input logic [1:0] burst, input int i);
        int base;
        base = int'(addr[11:2]);
        return (burst == FIXED) ? base : (base + i) % 1024;
    endfunction

    task automatic model_write(input logic [31:0] addr, input int len, input logic [1:0] burst);
        for (int i = 0; i <= len; i++) begin
            for (int b = 0; b < 4; b++) begin
                if (wstb[i][b]) ref_mem[word_at(addr, burst, i)][b*8 +: 8] = wdat[i][b*8 +: 8];
            end
        end
    endtask

    task automatic axi_write(input logic id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input int last_at, input bit rnd,
                             output logic [1:0] bresp_o, output logic bid_o, output bit ok);
        int n;
        int gap;
        bit done;
        logic [1:0] held;
        ok = 1'b1; bresp_o = 2'bxx; bid_o = 1'bx; held = 2'b00;
        bus.S_AXI_AWID = id; bus.S_AXI_AWADDR = addr; bus.S_AXI_AWLEN = len;
        bus.S_AXI_AWBURST = burst; bus.S_AXI_AWVALID = 1'b1;
        n = 0;
        while (bus.S_AXI_AWREADY !== 1'b1 && n < 1000) begin @(negedge aclk); n++; end
        if (n >= 1000) ok = 1'b0;
        @(negedge aclk);
        bus.S_AXI_AWVALID = 1'b0;
        if (bus.S_AXI_AWREADY !== 1'b0 || bus.S_AXI_WREADY !== 1'b1) ok = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            gap = rnd ? int'($urandom_range(2, 0)) : 0;
            repeat (gap) begin bus.S_AXI_WVALID = 1'b0; @(negedge aclk); end
            bus.S_AXI_WVALID = 1'b1; bus.S_AXI_WDATA = wdat[i];
            bus.S_AXI_WSTRB = wstb[i]; bus.S_AXI_WLAST = (i == last_at);
            if (bus.S_AXI_WREADY !== 1'b1) ok = 1'b0;
            @(negedge aclk);
        end
        bus.S_AXI_WVALID = 1'b0; bus.S_AXI_WLAST = 1'b0;
        if (bus.S_AXI_WREADY !== 1'b0 || bus.S_AXI_BVALID !== 1'b1) ok = 1'b0;
        done = 1'b0; n = 0;
        while (!done && n < 1000) begin
            bus.S_AXI_BREADY = rnd ? ($urandom_range(1, 0) == 1) : 1'b1;
            if (bus.S_AXI_BVALID !== 1'b1) begin ok = 1'b0; break; end
            if (n > 0 && bus.S_AXI_BRESP !== held) ok = 1'b0;
            held = bus.S_AXI_BRESP;
            if (bus.S_AXI_BREADY) begin
                bresp_o = bus.S_AXI_BRESP; bid_o = bus.S_AXI_BID; done = 1'b1;
            end
            @(negedge aclk); n++;
        end
        bus.S_AXI_BREADY = 1'b0;
        if (!done) ok = 1'b0;
        if (bus.S_AXI_BVALID !== 1'b0 || bus.S_AXI_AWREADY !== 1'b1) ok = 1'b0;
    endtask

    task automatic axi_read(input logic id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input bit rnd,
                            output int lat_o, output logic rid_o, output bit ok);
        int n;
        int got;
        bit stalled;
        logic [31:0] hd;
        logic hl, hi;
        ok = 1'b1; rid_o = 1'bx; hd = '0; hl = 1'b0; hi = 1'b0;
        bus.S_AXI_ARID = id; bus.S_AXI_ARADDR = addr; bus.S_AXI_ARLEN = len;
        bus.S_AXI_ARBURST = burst; bus.S_AXI_ARVALID = 1'b1;
        n = 0;
        while (bus.S_AXI_ARREADY !== 1'b1 && n < 1000) begin @(negedge aclk); n++; end
        if (n >= 1000) ok = 1'b0;
        @(negedge aclk);
        bus.S_AXI_ARVALID = 1'b0;
        if (bus.S_AXI_ARREADY !== 1'b0) ok = 1'b0;
        lat_o = 0;
        while (bus.S_AXI_RVALID !== 1'b1 && lat_o < 100) begin @(negedge aclk); lat_o++; end
        got = 0; stalled = 1'b0; n = 0;
        while (got <= int'(len) && n < 5000) begin
            bus.S_AXI_RREADY = rnd ? ($urandom_range(1, 0) == 1) : 1'b1;
            if (bus.S_AXI_RVALID !== 1'b1) begin ok = 1'b0; break; end
            if (stalled && (bus.S_AXI_RDATA !== hd || bus.S_AXI_RLAST !== hl || bus.S_AXI_RID !== hi))
                ok = 1'b0;
            if (bus.S_AXI_RREADY) begin
                rdat[got] = bus.S_AXI_RDATA; rlst[got] = bus.S_AXI_RLAST;
                rid_o = bus.S_AXI_RID; got++; stalled = 1'b0;
            end else begin
                hd = bus.S_AXI_RDATA; hl = bus.S_AXI_RLAST; hi = bus.S_AXI_RID; stalled = 1'b1;
            end
            @(negedge aclk); n++;
        end
        bus.S_AXI_RREADY = 1'b0;
        if (got <= int'(len)) ok = 1'b0;
        if (bus.S_AXI_ARREADY !== 1'b1 || bus.S_AXI_RVALID !== 1'b0) ok = 1'b0;
    endtask

    task automatic test_reset();
        logic [43:0] outs;
        aresetn = 1'b0;
        bus.S_AXI_AWID = 1'b0; bus.S_AXI_AWADDR = '0; bus.S_AXI_AWLEN = '0; bus.S_AXI_AWBURST = '0;
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WLAST = 1'b0;
        bus.S_AXI_WVALID = 1'b0; bus.S_AXI_BREADY = 1'b0; bus.S_AXI_ARID = 1'b0; bus.S_AXI_ARADDR = '0;
        bus.S_AXI_ARLEN = '0; bus.S_AXI_ARBURST = '0; bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b0;
        repeat (10) @(negedge aclk);
        outs = {bus.S_AXI_AWREADY, bus.S_AXI_ARREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID,
                bus.S_AXI_RVALID, bus.S_AXI_RLAST, bus.S_AXI_BRESP, bus.S_AXI_RRESP,
                bus.S_AXI_BID, bus.S_AXI_RID, bus.S_AXI_RDATA};
        total++;
        if (outs !== 44'h0) begin bad++; $display("FAIL reset_outputs: got %h want 0", outs); end
        aresetn = 1'b1;
        #1;
        total++;
        if ({bus.S_AXI_AWREADY, bus.S_AXI_ARREADY} !== 2'b00) begin
            bad++; $display("FAIL ready_before_edge: got %b want 00", {bus.S_AXI_AWREADY, bus.S_AXI_ARREADY});
        end
        @(negedge aclk);
        total++;
        if ({bus.S_AXI_AWREADY, bus.S_AXI_ARREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID, bus.S_AXI_RVALID} !== 5'b11000) begin
            bad++; $display("FAIL ready_after_edge: got %b want 11000",
                {bus.S_AXI_AWREADY, bus.S_AXI_ARREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID, bus.S_AXI_RVALID});
        end
    endtask

    task automatic test_incr_burst();
        logic id;
        for (int blk = 0; blk < 4; blk++) begin
            for (int i = 0; i < 256; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
            axi_write(1'b0, 32'(blk * 1024), 8'd255, INCR, 255, 1'b0, bresp, bid, wok);
            model_write(32'(blk * 1024), 255, INCR);
            total++;
            if (!wok || bresp !== 2'b00) begin bad++; $display("FAIL fill_write: got ok=%0d bresp=%b want ok=1 bresp=00", wok, bresp); end
        end
        id = ($urandom_range(1, 0) == 1);
        for (int i = 0; i < 256; i++) begin wdat[i] = 32'(i); wstb[i] = 4'hF; end
        axi_write(id, 32'h100, 8'd255, INCR, 255, 1'b0, bresp, bid, wok);
        model_write(32'h100, 255, INCR);
        total++; if (!wok) begin bad++; $display("FAIL incr_write_protocol: got 0 want 1"); end
        total++; if (bresp !== 2'b00) begin bad++; $display("FAIL incr_bresp: got %b want 00", bresp); end
        total++; if (bid !== id) begin bad++; $display("FAIL incr_bid: got %b want %b", bid, id); end
        id = ~id;
        axi_read(id, 32'h100, 8'd255, INCR, 1'b0, lat, rid_s, rok);
        total++; if (lat !== 2) begin bad++; $display("FAIL incr_read_latency: got %0d want 2", lat); end
        total++; if (!rok) begin bad++; $display("FAIL incr_read_protocol: got 0 want 1"); end
        total++; if (rid_s !== id) begin bad++; $display("FAIL incr_rid: got %b want %b", rid_s, id); end
        for (int i = 0; i < 256; i++) begin
            total++;
            if (rdat[i] !== 32'(i) || rlst[i] !== (i == 255)) begin
                bad++; $display("FAIL incr_beat%0d: got %h/%b want %h/%b", i, rdat[i], rlst[i], i, (i == 255));
            end
        end
    endtask

    task automatic test_strobe();
        wdat[0] = 32'h11223344; wstb[0] = 4'hF;
        axi_write(1'b1, 32'h20, 8'd0, INCR, 0, 1'b0, bresp, bid, wok);
        model_write(32'h20, 0, INCR);
        wdat[0] = 32'hAABBCCDD; wstb[0] = 4'b0101;
        axi_write(1'b0, 32'h20, 8'd0, INCR, 0, 1'b0, bresp, bid, wok);
        model_write(32'h20, 0, INCR);
        total++; if (!wok || bresp !== 2'b00) begin bad++; $display("FAIL strobe_write: got ok=%0d bresp=%b want ok=1 bresp=00", wok, bresp); end
        axi_read(1'b0, 32'h20, 8'd0, INCR, 1'b0, lat, rid_s, rok);
        total++;
        if (rdat[0] !== 32'h11BB33DD || rlst[0] !== 1'b1 || !rok) begin
            bad++; $display("FAIL strobe_data: got %h last=%b ok=%0d want 11bb33dd last=1 ok=1", rdat[0], rlst[0], rok);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] addr;
        logic [1:0]  burst;
        int          len;
        logic        id;
        for (int it = 0; it < 6; it++) begin
            len   = (it == 0) ? 15 : int'($urandom_range(15, 0));
            burst = (it == 0) ? INCR : 2'($urandom_range(2, 0));
            addr  = $urandom;
            id    = ($urandom_range(1, 0) == 1);
            for (int i = 0; i <= len; i++) begin wdat[i] = $urandom; wstb[i] = 4'($urandom_range(15, 0)); end
            axi_write(id, addr, 8'(len), burst, len, 1'b1, bresp, bid, wok);
            model_write(addr, len, burst);
            total++;
            if (!wok || bresp !== 2'b00 || bid !== id) begin
                bad++; $display("FAIL bp_write%0d: got ok=%0d bresp=%b bid=%b want ok=1 bresp=00 bid=%b", it, wok, bresp, bid, id);
            end
            axi_read(~id, addr, 8'(len), burst, 1'b1, lat, rid_s, rok);
            total++;
            if (!rok || rid_s !== ~id) begin bad++; $display("FAIL bp_read%0d: got ok=%0d rid=%b want ok=1 rid=%b", it, rok, rid_s, ~id); end
            for (int i = 0; i <= len; i++) begin
                total++;
                if (rdat[i] !== ref_mem[word_at(addr, burst, i)] || rlst[i] !== (i == len)) begin
                    bad++; $display("FAIL bp_beat%0d_%0d: got %h/%b want %h/%b", it, i, rdat[i], rlst[i],
                                    ref_mem[word_at(addr, burst, i)], (i == len));
                end
            end
        end
    endtask

    task automatic test_errors();
        for (int i = 0; i < 4; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
        axi_write(1'b0, 32'h300, 8'd3, INCR, 2, 1'b0, bresp, bid, wok);
        model_write(32'h300, 3, INCR);
        total++; if (!wok || bresp !== 2'b10) begin bad++; $display("FAIL early_wlast: got ok=%0d bresp=%b want ok=1 bresp=10", wok, bresp); end
        axi_read(1'b0, 32'h300, 8'd3, INCR, 1'b0, lat, rid_s, rok);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rdat[i] !== ref_mem[word_at(32'h300, INCR, i)]) begin
                bad++; $display("FAIL early_wlast_beat%0d: got %h want %h", i, rdat[i], ref_mem[word_at(32'h300, INCR, i)]);
            end
        end
        axi_write(1'b1, 32'h310, 8'd1, INCR, -1, 1'b0, bresp, bid, wok);
        model_write(32'h310, 1, INCR);
        total++; if (bresp !== 2'b10) begin bad++; $display("FAIL missing_wlast: got %b want 10", bresp); end
        axi_write(1'b1, 32'h320, 8'd2, INCR, 2, 1'b0, bresp, bid, wok);
        model_write(32'h320, 2, INCR);
        total++; if (bresp !== 2'b00) begin bad++; $display("FAIL err_cleared: got %b want 00", bresp); end
    endtask

    task automatic test_wrap();
        logic [31:0] a, b;
        a = $urandom; b = $urandom;
        wdat[0] = a; wdat[1] = b; wstb[0] = 4'hF; wstb[1] = 4'hF;
        axi_write(1'b0, 32'hFFC, 8'd1, INCR, 1, 1'b0, bresp, bid, wok);
        model_write(32'hFFC, 1, INCR);
        total++; if (!wok || bresp !== 2'b00) begin bad++; $display("FAIL wrap_write: got ok=%0d bresp=%b want ok=1 bresp=00", wok, bresp); end
        axi_read(1'b0, 32'h0, 8'd0, INCR, 1'b0, lat, rid_s, rok);
        total++; if (rdat[0] !== b) begin bad++; $display("FAIL wrap_word0: got %h want %h", rdat[0], b); end
        axi_read(1'b1, 32'hFFC, 8'd1, WRAP, 1'b0, lat, rid_s, rok);
        total++;
        if (rdat[0] !== a || rdat[1] !== b) begin bad++; $display("FAIL wrap_read: got %h %h want %h %h", rdat[0], rdat[1], a, b); end
    endtask

    task automatic test_concurrent();
        logic [31:0] v0, v1;
        bit          wok2, rok2;
        logic [1:0]  bresp2;
        logic        bid2, rid2;
        int          lat2;
        v0 = $urandom; v1 = ~v0;
        wdat[0] = v0; wstb[0] = 4'hF;
        axi_write(1'b0, 32'h40, 8'd0, INCR, 0, 1'b0, bresp, bid, wok);
        model_write(32'h40, 0, INCR);
        wdat[0] = v1;
        fork
            axi_write(1'b1, 32'h40, 8'd0, INCR, 0, 1'b0, bresp2, bid2, wok2);
            axi_read(1'b0, 32'h40, 8'd0, INCR, 1'b0, lat2, rid2, rok2);
        join
        total++; if (rdat[0] !== v0) begin bad++; $display("FAIL conc_old_data: got %h want %h", rdat[0], v0); end
        total++;
        if (!wok2 || !rok2 || bresp2 !== 2'b00 || bid2 !== 1'b1 || rid2 !== 1'b0 || lat2 !== 2) begin
            bad++; $display("FAIL conc_responses: got wok=%0d rok=%0d bresp=%b bid=%b rid=%b lat=%0d want 1 1 00 1 0 2",
                            wok2, rok2, bresp2, bid2, rid2, lat2);
        end
        model_write(32'h40, 0, INCR);
        axi_read(1'b1, 32'h40, 8'd0, INCR, 1'b0, lat, rid_s, rok);
        total++; if (rdat[0] !== ref_mem[16]) begin bad++; $display("FAIL conc_new_data: got %h want %h", rdat[0], ref_mem[16]); end
    endtask

    initial begin
        test_reset();
        test_incr_burst();
        test_strobe();
        test_backpressure();
        test_errors();
        test_wrap();
        test_concurrent();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
